// File: rtl/panel_run_control.sv
////////////////////////////////////////////////////////////////////////////////
// panel_run_control: front-panel run/stop/step controller for the SEQUENCER.
// Optional `HLT_INSTR_EN adds the HLT_INSTR input. Revision 1.0
////////////////////////////////////////////////////////////////////////////////
`default_nettype none

module panel_run_control #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_TIMEOUT    = 1024
) (
  input  logic CK,
  input  logic CLEAR,
  input  logic KEY_CONT,
  input  logic KEY_STOP,
  input  logic SW_SINGINST,
  input  logic SW_SINGSTEP,
  input  logic INSTR_DONE,
  input  logic CYCLE_DONE,
`ifdef HLT_INSTR_EN
  input  logic HLT_INSTR,
`endif
  output logic RUN,
  output logic HALT,
  output logic STEPI,
  output logic STEPC,
  output logic RUN_LAMP,
  output logic TIMEOUT_ERR
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int WD_W  = $clog2(STEP_TIMEOUT + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(STEP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HALTED   = 3'd0,
    S_RUNNING  = 3'd1,
    S_STOPPING = 3'd2,
    S_STEP_I   = 3'd3,
    S_STEP_C   = 3'd4
  } state_e;

  logic [3:0] raw_in;
  logic [1:0] key_evt;
  logic [1:0] sw_lvl;
  logic       hlt_req;

  assign raw_in = {SW_SINGSTEP, SW_SINGINST, KEY_STOP, KEY_CONT};

`ifdef HLT_INSTR_EN
  assign hlt_req = HLT_INSTR;
`else
  assign hlt_req = 1'b0;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    logic            sync1_q;
    logic            sync2_q;
    logic            deb_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge CK) begin
      if (CLEAR) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_in[gi];
        sync2_q <= sync1_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    if (gi < 2) begin : g_key
      logic             deb_prev_q;
      logic             armed_q;
      logic             evt_q;
      logic [ARM_W-1:0] arm_cnt_q;

      // Arming needs a confirmed-low run longer than the sync pipeline flush,
      // so the cleared-to-0 state after CLEAR alone can never arm a held key.
      always_ff @(posedge CK) begin
        if (CLEAR) begin
          deb_prev_q <= 1'b0;
          armed_q    <= 1'b0;
          evt_q      <= 1'b0;
          arm_cnt_q  <= '0;
        end else begin
          deb_prev_q <= deb_q;
          evt_q      <= deb_q & ~deb_prev_q & armed_q;
          if (!armed_q) begin
            if (sync2_q || deb_q) begin
              arm_cnt_q <= '0;
            end else if (arm_cnt_q == ARM_LAST) begin
              armed_q <= 1'b1;
            end else begin
              arm_cnt_q <= arm_cnt_q + 1'b1;
            end
          end
        end
      end

      assign key_evt[gi] = evt_q;
    end else begin : g_sw
      assign sw_lvl[gi-2] = deb_q;
    end
  end

  logic evt_cont;
  logic evt_stop;
  logic sw_sinst;
  logic sw_sstep;

  assign evt_cont = key_evt[0];
  assign evt_stop = key_evt[1];
  assign sw_sinst = sw_lvl[0];
  assign sw_sstep = sw_lvl[1];

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            run_q, run_d;
  logic            halt_q, halt_d;
  logic            stepi_q, stepi_d;
  logic            stepc_q, stepc_d;
  logic            lamp_q, lamp_d;
  logic            tmo_q, tmo_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_HALTED: begin
        if (evt_cont && !evt_stop) begin
          if (sw_sstep)      state_d = S_STEP_C;
          else if (sw_sinst) state_d = S_STEP_I;
          else               state_d = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (evt_stop || sw_sinst || sw_sstep || hlt_req) begin
          state_d = INSTR_DONE ? S_HALTED : S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (INSTR_DONE) begin
          state_d = S_HALTED;
        end else if (wd_expired) begin
          state_d = S_HALTED;
          tmo_d   = 1'b1;
        end
      end
      // The request pulse cycle still belongs to the previous operation, so a
      // done strobe seen there cannot be the answer to this step.
      S_STEP_I: begin
        if (INSTR_DONE && !stepi_q) begin
          state_d = S_HALTED;
        end else if (wd_expired) begin
          state_d = S_HALTED;
          tmo_d   = 1'b1;
        end
      end
      S_STEP_C: begin
        if (CYCLE_DONE && !stepc_q) begin
          state_d = S_HALTED;
        end else if (wd_expired) begin
          state_d = S_HALTED;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_HALTED;
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if (state_q inside {S_STOPPING, S_STEP_I, S_STEP_C}) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end

    run_d   = (state_d != S_HALTED);
    halt_d  = (state_d == S_HALTED) || (state_d == S_STOPPING);
    lamp_d  = (state_d == S_RUNNING) || (state_d == S_STOPPING);
    stepi_d = (state_d == S_STEP_I) && (state_q != S_STEP_I);
    stepc_d = (state_d == S_STEP_C) && (state_q != S_STEP_C);
  end

  always_ff @(posedge CK) begin
    if (CLEAR) begin
      state_q <= S_HALTED;
      wd_q    <= '0;
      run_q   <= 1'b0;
      halt_q  <= 1'b1;
      stepi_q <= 1'b0;
      stepc_q <= 1'b0;
      lamp_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
      stepi_q <= stepi_d;
      stepc_q <= stepc_d;
      lamp_q  <= lamp_d;
      tmo_q   <= tmo_d;
    end
  end

  assign RUN         = run_q;
  assign HALT        = halt_q;
  assign STEPI       = stepi_q;
  assign STEPC       = stepc_q;
  assign RUN_LAMP    = lamp_q;
  assign TIMEOUT_ERR = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_panel_run_control.sv
////////////////////////////////////////////////////////////////////////////////
// tb_panel_run_control: directed self-checking bench for panel_run_control.
// Revision 1.0
////////////////////////////////////////////////////////////////////////////////
`default_nettype none

module tb_panel_run_control;

  logic CK = 1'b0;
  logic CLEAR, KEY_CONT, KEY_STOP, SW_SINGINST, SW_SINGSTEP, INSTR_DONE, CYCLE_DONE;
`ifdef HLT_INSTR_EN
  logic HLT_INSTR;
`endif
  logic RUN, HALT, STEPI, STEPC, RUN_LAMP, TIMEOUT_ERR;

  int total = 0;
  int bad   = 0;

  panel_run_control #(
    .DEBOUNCE_CYCLES(4),
    .STEP_TIMEOUT   (16)
  ) dut (
    .CK         (CK),
    .CLEAR      (CLEAR),
    .KEY_CONT   (KEY_CONT),
    .KEY_STOP   (KEY_STOP),
    .SW_SINGINST(SW_SINGINST),
    .SW_SINGSTEP(SW_SINGSTEP),
    .INSTR_DONE (INSTR_DONE),
    .CYCLE_DONE (CYCLE_DONE),
`ifdef HLT_INSTR_EN
    .HLT_INSTR  (HLT_INSTR),
`endif
    .RUN        (RUN),
    .HALT       (HALT),
    .STEPI      (STEPI),
    .STEPC      (STEPC),
    .RUN_LAMP   (RUN_LAMP),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CK = ~CK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    CLEAR = 1'b1; KEY_CONT = 1'b0; KEY_STOP = 1'b0; SW_SINGINST = 1'b0; SW_SINGSTEP = 1'b0;
    INSTR_DONE = 1'b0; CYCLE_DONE = 1'b0;
`ifdef HLT_INSTR_EN
    HLT_INSTR = 1'b0;
`endif
    tick(2);
    check("rst_run", RUN, 1'b0);
    check("rst_halt", HALT, 1'b1);
    check("rst_stepi", STEPI, 1'b0);
    check("rst_stepc", STEPC, 1'b0);
    check("rst_lamp", RUN_LAMP, 1'b0);
    check("rst_tmo", TIMEOUT_ERR, 1'b0);
    CLEAR = 1'b0;
    tick(10);

    // CONT sampled at edge 0 must act at edge 7, not edge 6
    KEY_CONT = 1'b1;
    tick(7);
    check("cont_edge6_run", RUN, 1'b0);
    tick();
    check("cont_edge7_run", RUN, 1'b1);
    check("cont_edge7_halt", HALT, 1'b0);
    check("cont_edge7_lamp", RUN_LAMP, 1'b1);
    KEY_CONT = 1'b0;
    tick(10);
    check("running_hold_run", RUN, 1'b1);
    check("running_hold_halt", HALT, 1'b0);

    KEY_STOP = 1'b1;
    tick(8);
    check("stopping_halt", HALT, 1'b1);
    check("stopping_run", RUN, 1'b1);
    check("stopping_lamp", RUN_LAMP, 1'b1);
    KEY_STOP = 1'b0;
    tick(10);
    check("stopping_wait_run", RUN, 1'b1);
    INSTR_DONE = 1'b1; tick(); INSTR_DONE = 1'b0;
    check("stopped_run", RUN, 1'b0);
    check("stopped_halt", HALT, 1'b1);
    check("stopped_lamp", RUN_LAMP, 1'b0);

    // single instruction
    SW_SINGINST = 1'b1;
    tick(10);
    KEY_CONT = 1'b1;
    tick(8);
    check("stepi_pulse", STEPI, 1'b1);
    check("stepi_nostepc", STEPC, 1'b0);
    check("stepi_run", RUN, 1'b1);
    check("stepi_halt", HALT, 1'b0);
    check("stepi_lamp", RUN_LAMP, 1'b0);
    KEY_CONT = 1'b0;
    tick();
    check("stepi_once", STEPI, 1'b0);
    repeat (3) begin
      CYCLE_DONE = 1'b1; tick(); CYCLE_DONE = 1'b0; tick();
    end
    check("stepi_cycdone_ignored", RUN, 1'b1);
    INSTR_DONE = 1'b1; tick(); INSTR_DONE = 1'b0;
    check("stepi_done_run", RUN, 1'b0);
    check("stepi_done_halt", HALT, 1'b1);

    // single cycle wins over single instruction
    SW_SINGSTEP = 1'b1;
    tick(10);
    KEY_CONT = 1'b1;
    tick(8);
    check("stepc_pulse", STEPC, 1'b1);
    check("stepc_nostepi", STEPI, 1'b0);
    KEY_CONT = 1'b0;
    CYCLE_DONE = 1'b1; tick(); CYCLE_DONE = 1'b0;
    check("stepc_first_done_ignored", RUN, 1'b1);
    check("stepc_once", STEPC, 1'b0);
    CYCLE_DONE = 1'b1; tick(); CYCLE_DONE = 1'b0;
    check("stepc_done_run", RUN, 1'b0);
    check("stepc_done_halt", HALT, 1'b1);

    tick(10);
    KEY_CONT = 1'b1; tick(2); KEY_CONT = 1'b0;
    tick(12);
    check("glitch_run", RUN, 1'b0);
    check("glitch_stepc", STEPC, 1'b0);

    // watchdog: 16 cycles in STEP_I then forced halt
    SW_SINGSTEP = 1'b0;
    tick(10);
    KEY_CONT = 1'b1;
    tick(8);
    check("tmo_stepi", STEPI, 1'b1);
    KEY_CONT = 1'b0;
    tick(15);
    check("tmo_cycle16_run", RUN, 1'b1);
    check("tmo_cycle16_err", TIMEOUT_ERR, 1'b0);
    tick();
    check("tmo_run", RUN, 1'b0);
    check("tmo_halt", HALT, 1'b1);
    check("tmo_err", TIMEOUT_ERR, 1'b1);
    tick();
    check("tmo_err_pulse", TIMEOUT_ERR, 1'b0);

    // key held through CLEAR must not fire until re-pressed
    SW_SINGINST = 1'b0;
    KEY_CONT = 1'b1;
    CLEAR = 1'b1; tick(2); CLEAR = 1'b0;
    tick(15);
    check("held_key_run", RUN, 1'b0);
    KEY_CONT = 1'b0;
    tick(15);
    KEY_CONT = 1'b1;
    tick(8);
    check("rearm_run", RUN, 1'b1);
    KEY_CONT = 1'b0;

    tick(10);
    SW_SINGINST = 1'b1;
    tick(8);
    check("sw_stop_halt", HALT, 1'b1);
    check("sw_stop_run", RUN, 1'b1);

    CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    SW_SINGINST = 1'b0;
    check("midclear_run", RUN, 1'b0);
    check("midclear_halt", HALT, 1'b1);
    check("midclear_lamp", RUN_LAMP, 1'b0);

`ifdef HLT_INSTR_EN
    tick(10);
    KEY_CONT = 1'b1;
    tick(8);
    KEY_CONT = 1'b0;
    check("hlt_pre_halt", HALT, 1'b0);
    HLT_INSTR = 1'b1; tick(); HLT_INSTR = 1'b0;
    check("hlt_halt", HALT, 1'b1);
    check("hlt_lamp", RUN_LAMP, 1'b1);
    check("hlt_run", RUN, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
